muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide execution unit of the MIPS core, with architectural HI/LO registers.
- Operands come straight from the register file read ports (rs on port 1, rt on port 2).
- MFHI/MFLO results go back through a one-cycle write request into the register file write port (we/addr/data).
- Issue logic stalls on busy_o; nothing else in the pipeline waits on this block.

Parameters:
- FAST_MUL, 1, 1 = single-cycle multiply array; 0 = iterative shift-add multiply (32 iterations).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  operation request valid.
- op_i  in  3  muldiv_op_e: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- rs_data_i  in  32  rs operand (register file read data 1).
- rt_data_i  in  32  rt operand (register file read data 2).
- dst_i  in  5  destination register for MFHI/MFLO.
- flush_i  in  1  abort the in-flight operation (exception/redirect).
- ready_o  out  1  idle; a request is accepted this cycle.
- busy_o  out  1  multi-cycle operation in flight (equals !ready_o).
- wb_we_o  out  1  register-file write request, one-cycle pulse.
- wb_addr_o  out  5  write address.
- wb_data_o  out  32  write data.
- hi_o  out  32  current HI.
- lo_o  out  32  current LO.

Behaviour:
- Reset (synchronous, any state, including mid-operation):
  - HI = LO = 0, FSM = IDLE.
  - ready_o = 1, busy_o = 0, wb_we_o = 0, wb_addr_o = 0, wb_data_o = 0.
- Accept rule: a request is accepted on a rising edge where start_i && ready_o. When not ready, start_i is ignored with no side effects; upstream must hold the request.
- FSM states: IDLE, MUL, DIV, DONE.
- MTHI / MTLO:
  - HI or LO ← rs_data_i at the accept edge.
  - FSM stays in IDLE; no busy cycle.
- MFHI / MFLO:
  - At the accept edge: wb_we_o ← (dst_i != 0), wb_addr_o ← dst_i, wb_data_o ← HI or LO.
  - wb_we_o is high for exactly one cycle; FSM stays in IDLE.
  - Back-to-back MT*/MF* in consecutive cycles: MF* sees the value written by the preceding MT*.
- wb_we_o is 0 on every cycle not directly following an MFHI/MFLO accept.
- MULT / MULTU:
  - Full 64-bit product {HI, LO}; signed or unsigned per op.
  - FAST_MUL = 1: IDLE → DONE; busy_o is high for 1 cycle.
  - FAST_MUL = 0: IDLE → MUL for 32 cycles → DONE; busy_o is high for 33 cycles.
- DIV / DIVU:
  - Restoring divider on operand magnitudes, one quotient bit per cycle: IDLE → DIV (32 cycles) → DONE; busy_o is high for 33 cycles.
  - DONE applies the sign fixup: quotient truncates toward zero, remainder takes the dividend's sign. LO = quotient, HI = remainder.
- Divide special cases (detected at accept; go straight to DONE, busy for 1 cycle):
  - Divide by zero (rt = 0): LO = 0xFFFFFFFF, HI = rs.
  - Signed DIV with 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Commit: HI/LO are written only at the DONE → IDLE edge. ready_o rises in the cycle after that edge.
- Operand capture: rs/rt are latched at accept; later changes on the input ports have no effect.
- flush_i:
  - In MUL, DIV or DONE: next state is IDLE, HI/LO keep their pre-operation values, no commit.
  - In IDLE: flush_i wins over a simultaneous start_i, so the request is not accepted.
- Reset has priority over flush_i, which has priority over start_i.

Decomposition:
- Package muldiv_pkg holds:
  - muldiv_op_e: 3-bit enum, MULT = 0, MULTU = 1, DIV = 2, DIVU = 3, MFHI = 4, MFLO = 5, MTHI = 6, MTLO = 7.
  - muldiv_state_e.
  - constant MULDIV_ITERS = 32.
- Sub-module div_iter: the unsigned restoring divider datapath (remainder/quotient shift registers, iteration counter). The wrapper owns sign handling, special cases, the FSM and HI/LO.

Test Plan:
- MULT rs = 0xFFFFFFFD (-3), rt = 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. With FAST_MUL = 1, busy_o is high for exactly 1 cycle.
- MULTU rs = rt = 0xFFFFFFFF with FAST_MUL = 0 → busy_o high for 33 cycles, then HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV rs = 0xFFFFFFF9 (-7), rt = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF after 33 busy cycles. DIVU of the same operands → LO = 0x7FFFFFFC, HI = 0x00000001.
- DIV rs = 0x12345678, rt = 0 → LO = 0xFFFFFFFF, HI = 0x12345678, 1 busy cycle. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- MTLO rs = 0xCAFEF00D, then MFLO dst = 8 in the next cycle → single wb_we_o pulse, addr = 8, data = 0xCAFEF00D. MFHI dst = 0 → wb_we_o stays 0.
- DIV in flight: flush_i on iteration 10 → ready_o = 1 the next cycle, HI/LO unchanged. A new DIV then completes normally. rst_i mid-DIV → HI = LO = 0, ready_o = 1 after the edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the multiply/divide unit
package muldiv_pkg;

    // Operation codes presented on op_i.
    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MFHI  = 3'd4,
        MFLO  = 3'd5,
        MTHI  = 3'd6,
        MTLO  = 3'd7
    } muldiv_op_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_e;

    // Iterations of the shift-add multiplier and the restoring divider.
    localparam int MULDIV_ITERS = 32;

    // Magnitude of a 32-bit operand; only negated when treated as signed.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - unsigned restoring divider datapath, one quotient bit per step
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   load_i            capture dividend/divisor and clear the iteration counter
//   step_i            perform one restoring iteration
//   dividend_i        unsigned dividend (captured on load_i)
//   divisor_i         unsigned divisor, non-zero (captured on load_i)
//   quotient_o        quotient, valid after the last step
//   remainder_o       remainder, valid after the last step
//   last_o            the current step is the final iteration
module div_iter
    import muldiv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        last_o
);

    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] shifted;
    logic [33:0] trial;

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        // quo_q holds the not-yet-consumed dividend bits in its upper end,
        // and the quotient bits shift in from the bottom.
        shifted = {rem_q, quo_q[31]};
        trial   = {1'b0, shifted} - {2'b00, dvs_q};
        if (load_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
            cnt_d = '0;
        end else if (step_i) begin
            // A non-negative trial is always below the divisor, so bit 32 is
            // clear whenever the subtraction fits.
            if (trial[33:32] == 2'b00) begin
                rem_d = trial[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = shifted[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
    assign last_o      = (cnt_q == 5'(MULDIV_ITERS - 1));

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle multiply/divide unit with architectural HI/LO
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   start_i, op_i          request valid and operation (muldiv_op_e)
//   rs_data_i, rt_data_i   register file read operands
//   dst_i                  destination register for MFHI/MFLO
//   flush_i                abort the in-flight operation / block a new one
//   ready_o, busy_o        idle (request accepted) / operation in flight
//   wb_we_o, wb_addr_o,
//   wb_data_o              one-cycle register file write for MFHI/MFLO
//   hi_o, lo_o             current HI and LO
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int FAST_MUL = 1
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic [4:0]  dst_i,
    input  logic        flush_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam bit FAST = (FAST_MUL != 0);

    muldiv_state_e state_q, state_d;
    muldiv_op_e    op_q, op_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          neg_q, neg_d;        // negate product / quotient
    logic          rneg_q, rneg_d;      // negate remainder
    logic          special_q, special_d;
    logic [63:0]   spec_q, spec_d;      // {HI, LO} for divide special cases
    logic [31:0]   mag_a_q, mag_a_d;
    logic [31:0]   mag_b_q, mag_b_d;
    logic [63:0]   mcand_q, mcand_d;
    logic [31:0]   mplier_q, mplier_d;
    logic [63:0]   prod_q, prod_d;
    logic [4:0]    mcnt_q, mcnt_d;
    logic          wb_we_q, wb_we_d;
    logic [4:0]    wb_addr_q, wb_addr_d;
    logic [31:0]   wb_data_q, wb_data_d;

    muldiv_op_e    op_in;
    logic          sg_in;
    logic [31:0]   mag_a_in, mag_b_in;
    logic          div_load, div_step, div_last;
    logic [31:0]   div_quo, div_rem;
    logic [63:0]   mul_mag, mul_res;
    logic [31:0]   quo_res, rem_res;
    logic          is_mul_q;
    logic [63:0]   commit_val;

    assign op_in    = muldiv_op_e'(op_i);
    assign sg_in    = (op_in == MULT) || (op_in == DIV);
    assign mag_a_in = abs32(rs_data_i, sg_in);
    assign mag_b_in = abs32(rt_data_i, sg_in);

    div_iter u_div_iter (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (div_load),
        .step_i      (div_step),
        .dividend_i  (mag_a_in),
        .divisor_i   (mag_b_in),
        .quotient_o  (div_quo),
        .remainder_o (div_rem),
        .last_o      (div_last)
    );

    // Both datapaths work on magnitudes; signs are re-applied at commit.
    assign mul_mag    = FAST ? ({32'b0, mag_a_q} * {32'b0, mag_b_q}) : prod_q;
    assign mul_res    = neg_q  ? (~mul_mag + 64'd1) : mul_mag;
    assign quo_res    = neg_q  ? (~div_quo + 32'd1) : div_quo;
    assign rem_res    = rneg_q ? (~div_rem + 32'd1) : div_rem;
    assign is_mul_q   = (op_q == MULT) || (op_q == MULTU);
    assign commit_val = special_q ? spec_q : (is_mul_q ? mul_res : {rem_res, quo_res});

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        special_d = special_q;
        spec_d    = spec_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        mcnt_d    = mcnt_q;
        wb_we_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        div_load  = 1'b0;
        div_step  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // flush_i blocks acceptance of a simultaneous request.
                if (start_i && !flush_i) begin
                    op_d      = op_in;
                    neg_d     = sg_in && (rs_data_i[31] ^ rt_data_i[31]);
                    rneg_d    = sg_in && rs_data_i[31];
                    special_d = 1'b0;
                    case (op_in)
                        MULT, MULTU: begin
                            mag_a_d  = mag_a_in;
                            mag_b_d  = mag_b_in;
                            mcand_d  = {32'b0, mag_a_in};
                            mplier_d = mag_b_in;
                            prod_d   = '0;
                            mcnt_d   = '0;
                            state_d  = FAST ? S_DONE : S_MUL;
                        end
                        DIV, DIVU: begin
                            if (rt_data_i == 32'd0) begin
                                special_d = 1'b1;
                                spec_d    = {rs_data_i, 32'hFFFF_FFFF};
                                state_d   = S_DONE;
                            end else if (op_in == DIV && rs_data_i == 32'h8000_0000 &&
                                         rt_data_i == 32'hFFFF_FFFF) begin
                                special_d = 1'b1;
                                spec_d    = {32'h0, 32'h8000_0000};
                                state_d   = S_DONE;
                            end else begin
                                div_load = 1'b1;
                                state_d  = S_DIV;
                            end
                        end
                        MFHI: begin
                            wb_we_d   = (dst_i != 5'd0);
                            wb_addr_d = dst_i;
                            wb_data_d = hi_q;
                        end
                        MFLO: begin
                            wb_we_d   = (dst_i != 5'd0);
                            wb_addr_d = dst_i;
                            wb_data_d = lo_q;
                        end
                        MTHI: hi_d = rs_data_i;
                        MTLO: lo_d = rs_data_i;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (mplier_q[0]) begin
                        prod_d = prod_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    mcnt_d   = mcnt_q + 5'd1;
                    if (mcnt_q == 5'(MULDIV_ITERS - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DIV: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    div_step = 1'b1;
                    if (div_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!flush_i) begin
                    {hi_d, lo_d} = commit_val;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            op_q      <= MULT;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            special_q <= 1'b0;
            spec_q    <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            mcnt_q    <= '0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            special_q <= special_d;
            spec_q    <= spec_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            prod_q    <= prod_d;
            mcnt_q    <= mcnt_d;
            wb_we_q   <= wb_we_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign ready_o   = (state_q == S_IDLE);
    assign busy_o    = (state_q != S_IDLE);
    assign wb_we_o   = wb_we_q;
    assign wb_addr_o = wb_addr_q;
    assign wb_data_o = wb_data_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit (fast and iterative multiplier)
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic [4:0]  dst = '0;

    logic        ready_w   [2];
    logic        busy_w    [2];
    logic        wb_we_w   [2];
    logic [4:0]  wb_addr_w [2];
    logic [31:0] wb_data_w [2];
    logic [31:0] hi_w      [2];
    logic [31:0] lo_w      [2];

    always #5 clk = ~clk;

    // Instance 0 uses the single-cycle multiplier, instance 1 the iterative one.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        muldiv_unit #(.FAST_MUL(g == 0 ? 1 : 0)) dut (
            .clk_i     (clk),
            .rst_i     (rst),
            .start_i   (start),
            .op_i      (op),
            .rs_data_i (rs),
            .rt_data_i (rt),
            .dst_i     (dst),
            .flush_i   (flush),
            .ready_o   (ready_w[g]),
            .busy_o    (busy_w[g]),
            .wb_we_o   (wb_we_w[g]),
            .wb_addr_o (wb_addr_w[g]),
            .wb_data_o (wb_data_w[g]),
            .hi_o      (hi_w[g]),
            .lo_o      (lo_w[g])
        );
    end

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } hilo_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    hilo_t       hilo_q [2][$];
    wb_t         wb_q   [2][$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expected {HI,LO,busy length} whenever busy drops, and an
    // expected write whenever wb_we_o pulses.
    bit    busy_prev [2];
    int    busy_cnt  [2];
    hilo_t e;
    wb_t   w;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("ready_vs_busy[%0d]", i), {63'b0, ready_w[i]}, {63'b0, !busy_w[i]});
                if (busy_w[i]) busy_cnt[i]++;
                if (busy_prev[i] && !busy_w[i]) begin
                    if (hilo_q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL commit[%0d]: completion with no expected entry", i);
                    end else begin
                        e = hilo_q[i].pop_front();
                        chk($sformatf("hi[%0d]", i), {32'b0, hi_w[i]}, {32'b0, e.hi});
                        chk($sformatf("lo[%0d]", i), {32'b0, lo_w[i]}, {32'b0, e.lo});
                        if (e.len >= 0)
                            chk($sformatf("busy_len[%0d]", i), 64'(busy_cnt[i]), 64'(e.len));
                    end
                    busy_cnt[i] = 0;
                end
                if (wb_we_w[i]) begin
                    if (wb_q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wb[%0d]: unexpected write addr %0d data %0h", i, wb_addr_w[i], wb_data_w[i]);
                    end else begin
                        w = wb_q[i].pop_front();
                        chk($sformatf("wb_addr[%0d]", i), {59'b0, wb_addr_w[i]}, {59'b0, w.addr});
                        chk($sformatf("wb_data[%0d]", i), {32'b0, wb_data_w[i]}, {32'b0, w.data});
                    end
                end
                busy_prev[i] = busy_w[i];
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!(ready_w[0] && ready_w[1]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: timeout after %0d cycles", n);
        end
    endtask

    // mode 0: run to completion; 1: flush during busy cycle k; 2: reset during busy cycle k.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input int mode, input int k);
        logic [31:0]     nhi, nlo;
        int              lf, ls;
        longint          sp;
        longint unsigned up;
        bit              multi;
        wb_t             wr;
        hilo_t           ent;
        wait_ready();
        nhi = m_hi; nlo = m_lo; lf = 1; ls = 1; multi = 1'b1;
        case (o)
            MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {nhi, nlo} = sp;
                ls = 33;
            end
            MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                {nhi, nlo} = up;
                ls = 33;
            end
            DIV: begin
                if (b == 0) begin
                    nlo = 32'hFFFF_FFFF; nhi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    nlo = 32'h8000_0000; nhi = 32'h0;
                end else begin
                    nlo = 32'($signed(a) / $signed(b));
                    nhi = 32'($signed(a) % $signed(b));
                    lf = 33; ls = 33;
                end
            end
            DIVU: begin
                if (b == 0) begin
                    nlo = 32'hFFFF_FFFF; nhi = a;
                end else begin
                    nlo = a / b; nhi = a % b;
                    lf = 33; ls = 33;
                end
            end
            MFHI, MFLO: begin
                multi = 1'b0;
                if (d != 5'd0) begin
                    wr.addr = d;
                    wr.data = (o == MFHI) ? m_hi : m_lo;
                    wb_q[0].push_back(wr);
                    wb_q[1].push_back(wr);
                end
            end
            default: begin
                multi = 1'b0;
                if (o == MTHI) m_hi = a; else m_lo = a;
            end
        endcase
        start = 1'b1; op = o; rs = a; rt = b; dst = d;
        if (multi) begin
            if (mode == 1) begin nhi = m_hi; nlo = m_lo; lf = k; ls = k; end
            if (mode == 2) begin nhi = '0;   nlo = '0;   lf = k; ls = k; end
            ent.hi = nhi; ent.lo = nlo;
            ent.len = lf; hilo_q[0].push_back(ent);
            ent.len = ls; hilo_q[1].push_back(ent);
            m_hi = nhi; m_lo = nlo;
        end
        @(negedge clk);
        start = 1'b0;
        rs = $urandom;
        rt = $urandom;
        if (mode != 0) begin
            repeat (k - 1) @(negedge clk);
            if (mode == 1) flush = 1'b1; else rst = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            rst = 1'b0;
        end
    endtask

    task automatic expect_hilo(input logic [31:0] h, input logic [31:0] l);
        wait_ready();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("hi_direct[%0d]", i), {32'b0, hi_w[i]}, {32'b0, h});
            chk($sformatf("lo_direct[%0d]", i), {32'b0, lo_w[i]}, {32'b0, l});
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'(-$urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    int          r_mode, r_k;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rst_hi",      {32'b0, hi_w[i]},      64'h0);
            chk("rst_lo",      {32'b0, lo_w[i]},      64'h0);
            chk("rst_ready",   {63'b0, ready_w[i]},   64'h1);
            chk("rst_busy",    {63'b0, busy_w[i]},    64'h0);
            chk("rst_wb_we",   {63'b0, wb_we_w[i]},   64'h0);
            chk("rst_wb_addr", {59'b0, wb_addr_w[i]}, 64'h0);
            chk("rst_wb_data", {32'b0, wb_data_w[i]}, 64'h0);
        end
        mon_en = 1'b1;

        do_op(MULT,  32'hFFFF_FFFD, 32'd5,         5'd0, 0, 0);
        expect_hilo(32'hFFFF_FFFF, 32'hFFFF_FFF1);
        do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 0, 0);
        expect_hilo(32'hFFFF_FFFE, 32'h0000_0001);
        do_op(DIV,   32'hFFFF_FFF9, 32'd2,         5'd0, 0, 0);
        expect_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op(DIVU,  32'hFFFF_FFF9, 32'd2,         5'd0, 0, 0);
        expect_hilo(32'h0000_0001, 32'h7FFF_FFFC);
        do_op(DIV,   32'h1234_5678, 32'd0,         5'd0, 0, 0);
        expect_hilo(32'h1234_5678, 32'hFFFF_FFFF);
        do_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0, 0);
        expect_hilo(32'h0, 32'h8000_0000);

        do_op(MTLO, 32'hCAFE_F00D, 32'd0, 5'd0, 0, 0);
        do_op(MFLO, 32'd0,         32'd0, 5'd8, 0, 0);
        do_op(MFHI, 32'd0,         32'd0, 5'd0, 0, 0);
        repeat (3) @(negedge clk);

        // Flush in IDLE wins over start: this MTHI must not land.
        wait_ready();
        start = 1'b1; op = MTHI; rs = 32'hDEAD_BEEF; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        do_op(MFHI, 32'd0, 32'd0, 5'd5, 0, 0);

        do_op(DIV, 32'd1000, 32'd7, 5'd0, 1, 10);
        expect_hilo(32'h0, 32'hCAFE_F00D);
        do_op(DIV, 32'd1000, 32'd7, 5'd0, 0, 0);
        expect_hilo(32'd6, 32'd142);
        do_op(DIV, 32'd5, 32'd3, 5'd0, 2, 10);
        expect_hilo(32'h0, 32'h0);

        for (int n = 0; n < 200; n++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a = rnd_operand();
            r_b = rnd_operand();
            r_mode = 0;
            r_k = 0;
            if ((r_op == DIV || r_op == DIVU) && r_b != 0 &&
                !(r_op == DIV && r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF) &&
                $urandom_range(0, 7) == 0) begin
                r_mode = 1;
                r_k = $urandom_range(1, 33);
            end
            do_op(r_op, r_a, r_b, 5'($urandom_range(0, 31)), r_mode, r_k);
        end

        wait_ready();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("hilo_queue_empty", 64'(hilo_q[i].size()), 64'h0);
            chk("wb_queue_empty",   64'(wb_q[i].size()),   64'h0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
